// File: rtl/axi4_stitch_wr_arbiter.sv
// Two-requester AXI4 write arbiter stitching two half-width video streams into one
// double-width, double-buffered frame buffer; one burst in flight at a time.
module axi4_stitch_wr_arbiter #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned IMG_HDISP  = 640,
    parameter int unsigned IMG_VDISP  = 480,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter logic [31:0] BUF_STRIDE = 32'h0038_4000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_rdy,
    input  logic [1:0]            req_sof,
    input  logic [DATA_WIDTH-1:0] req_data0,
    input  logic [DATA_WIDTH-1:0] req_data1,
    output logic [1:0]            req_ren,
    output logic [31:0]           m_awaddr,
    output logic [7:0]            m_awlen,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic                  m_wvalid,
    output logic                  m_wlast,
    input  logic                  m_wready,
    input  logic                  m_bvalid,
    input  logic [1:0]            m_bresp,
    output logic                  m_bready,
    output logic [1:0]            frame_done,
    output logic [1:0]            buf_sel,
    output logic                  err
);

    localparam int unsigned BURST_BYTES = BURST_LEN * DATA_WIDTH / 8;
    localparam int unsigned COLS        = IMG_HDISP * 4 / BURST_BYTES;
    localparam int unsigned COL_W       = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned LINE_W      = (IMG_VDISP > 1) ? $clog2(IMG_VDISP) : 1;
    localparam int unsigned BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [31:0]        LINE_BYTES = 32'(IMG_HDISP * 8);
    localparam logic [31:0]        HALF_BYTES = 32'(IMG_HDISP * 4);
    localparam logic [31:0]        BURST_B32  = 32'(BURST_BYTES);
    localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(COLS - 1);
    localparam logic [LINE_W-1:0]  LINE_LAST  = LINE_W'(IMG_VDISP - 1);
    localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

    state_t                   state, state_nxt;
    logic                     grant_q, last_grant_q, grant_nxt, start, b_done;
    logic [31:0]              addr_q, addr_nxt;
    logic [BEAT_W-1:0]        beat_q;
    logic [1:0][COL_W-1:0]    col_q;
    logic [1:0][LINE_W-1:0]   line_q;
    logic [1:0]               sof_pend_q, buf_sel_q, frame_done_q, busy;
    logic                     err_q;

    always_comb begin
        start     = (state == S_IDLE) && (req_rdy != 2'b00);
        grant_nxt = (&req_rdy) ? ~last_grant_q : req_rdy[1];
        b_done    = (state == S_B) && m_bvalid;
        addr_nxt  = BASE_ADDR
                  + (buf_sel_q[grant_nxt] ? BUF_STRIDE : 32'd0)
                  + 32'(line_q[grant_nxt]) * LINE_BYTES
                  + (grant_nxt ? HALF_BYTES : 32'd0)
                  + 32'(col_q[grant_nxt]) * BURST_B32;
        // The grant cycle already counts as mid-burst so a coincident sof cannot
        // clear counters after the old address has been latched.
        busy[0] = ((state != S_IDLE) && !grant_q) || (start && !grant_nxt);
        busy[1] = ((state != S_IDLE) &&  grant_q) || (start &&  grant_nxt);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_AW;
            S_AW:    if (m_awready) state_nxt = S_W;
            S_W:     if (m_wready && (beat_q == BEAT_LAST)) state_nxt = S_B;
            S_B:     if (m_bvalid) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        m_awvalid = (state == S_AW);
        m_awaddr  = m_awvalid ? addr_q : '0;
        m_awlen   = 8'(BURST_LEN - 1);
        m_wvalid  = (state == S_W);
        m_wdata   = m_wvalid ? (grant_q ? req_data1 : req_data0) : '0;
        m_wlast   = m_wvalid && (beat_q == BEAT_LAST);
        req_ren   = (m_wvalid && m_wready) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
        m_bready  = (state == S_B);
    end

    assign frame_done = frame_done_q;
    assign buf_sel    = buf_sel_q;
    assign err        = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            beat_q       <= '0;
            col_q        <= '0;
            line_q       <= '0;
            sof_pend_q   <= '0;
            buf_sel_q    <= '0;
            frame_done_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state        <= state_nxt;
            frame_done_q <= '0;
            if (start) begin
                grant_q      <= grant_nxt;
                last_grant_q <= grant_nxt;
                addr_q       <= addr_nxt;
            end
            if (state == S_AW)
                beat_q <= '0;
            else if (m_wvalid && m_wready)
                beat_q <= beat_q + BEAT_W'(1);
            if (b_done && (m_bresp != 2'b00))
                err_q <= 1'b1;
            for (int unsigned k = 0; k < 2; k++) begin
                if (b_done && (grant_q == 1'(k))) begin
                    sof_pend_q[k] <= 1'b0;
                    if (sof_pend_q[k] || req_sof[k]) begin
                        col_q[k]  <= '0;
                        line_q[k] <= '0;
                    end else if (col_q[k] == COL_LAST) begin
                        col_q[k] <= '0;
                        if (line_q[k] == LINE_LAST) begin
                            line_q[k]       <= '0;
                            buf_sel_q[k]    <= ~buf_sel_q[k];
                            frame_done_q[k] <= 1'b1;
                        end else begin
                            line_q[k] <= line_q[k] + LINE_W'(1);
                        end
                    end else begin
                        col_q[k] <= col_q[k] + COL_W'(1);
                    end
                end else if (req_sof[k]) begin
                    if (busy[k]) begin
                        sof_pend_q[k] <= 1'b1;
                    end else begin
                        col_q[k]  <= '0;
                        line_q[k] <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_axi4_stitch_wr_arbiter.sv
// Randomized bench for axi4_stitch_wr_arbiter against a frame-position reference model.
module tb_axi4_stitch_wr_arbiter;

    localparam int          DW     = 64;
    localparam int          BL     = 16;
    localparam int          H      = 640;
    localparam int          V      = 4;
    localparam logic [31:0] BASE   = 32'h1000_0000;
    localparam logic [31:0] STRIDE = 32'h0038_4000;
    localparam int          COLS   = H * 4 / (BL * DW / 8);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    req_rdy = '0, req_sof = '0, req_ren;
    logic [DW-1:0] req_data0 = '0, req_data1 = '0, m_wdata;
    logic [31:0]   m_awaddr;
    logic [7:0]    m_awlen;
    logic          m_awvalid, m_awready = 1'b0;
    logic          m_wvalid, m_wlast, m_wready = 1'b0;
    logic          m_bvalid = 1'b0, m_bready;
    logic [1:0]    m_bresp = '0, frame_done, buf_sel;
    logic          err;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: frame position per requester
    int col_m[2], line_m[2];
    bit buf_m[2], pend_m[2];
    bit err_m;
    int last_m;

    logic [31:0] got_addr;
    logic [1:0]  got_fd;

    always #5 clk = ~clk;

    axi4_stitch_wr_arbiter #(
        .DATA_WIDTH(DW), .BURST_LEN(BL), .IMG_HDISP(H), .IMG_VDISP(V),
        .BASE_ADDR(BASE), .BUF_STRIDE(STRIDE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_rdy(req_rdy), .req_sof(req_sof),
        .req_data0(req_data0), .req_data1(req_data1), .req_ren(req_ren),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
        .frame_done(frame_done), .buf_sel(buf_sel), .err(err)
    );

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_addr(input int k);
        logic [31:0] a;
        a = BASE + (buf_m[k] ? STRIDE : 32'd0) + 32'(line_m[k] * H * 8)
                 + 32'(k * H * 4) + 32'(col_m[k] * (BL * DW / 8));
        return a;
    endfunction

    function automatic logic [DW-1:0] rnd_word();
        return {$urandom, $urandom};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req_rdy = '0; req_sof = '0;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = '0;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_awvalid", m_awvalid, 0);
        check_val("rst_awaddr", m_awaddr, 0);
        check_val("rst_awlen", m_awlen, BL - 1);
        check_val("rst_wvalid", m_wvalid, 0);
        check_val("rst_wdata", m_wdata, 0);
        check_val("rst_wlast", m_wlast, 0);
        check_val("rst_ren", req_ren, 0);
        check_val("rst_bready", m_bready, 0);
        check_val("rst_frame_done", frame_done, 0);
        check_val("rst_buf_sel", buf_sel, 0);
        check_val("rst_err", err, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            col_m[k] = 0; line_m[k] = 0; buf_m[k] = 0; pend_m[k] = 0;
        end
        err_m = 0; last_m = 1;
    endtask

    // One complete burst; caller is just after a falling edge with the DUT idle.
    task automatic run_burst(input logic [1:0] rdy, input int aw_dly, input int w_hold,
                             input int b_dly, input logic [1:0] bresp,
                             input logic [1:0] sof_mask, input int sof_cyc);
        int k, cyc, beats;
        bit seen, pop;
        logic [31:0] exp_addr;
        logic [1:0] fd_exp;
        k = (rdy == 2'b11) ? (1 - last_m) : (rdy[0] ? 0 : 1);
        exp_addr = model_addr(k);
        got_addr = '0;
        got_fd = '0;
        req_rdy = rdy;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            if (m_awvalid) begin seen = 1; break; end
        end
        check_val("aw_seen", seen, 1);
        req_rdy = '0;
        if (!seen) return;
        last_m = k;
        got_addr = m_awaddr;
        check_val("awlen", m_awlen, BL - 1);
        for (int c = 0; c <= aw_dly; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            m_awready = (c >= aw_dly);
            check_val("awvalid", m_awvalid, 1);
            check_val("awaddr", m_awaddr, exp_addr);
            check_val("aw_wvalid", m_wvalid, 0);
            check_val("aw_ren", req_ren, 0);
        end
        cyc = 0; beats = 0; pop = 0;
        while (beats < BL && cyc < 300) begin
            @(negedge clk);
            if (pop) begin
                if (k == 0) req_data0 = rnd_word(); else req_data1 = rnd_word();
                pop = 0;
            end
            m_awready = 1'b0;
            m_wready = (cyc >= w_hold) && ($urandom_range(0, 3) != 0);
            if (cyc == sof_cyc && sof_mask != 2'b00) begin
                req_sof = sof_mask;
                for (int s = 0; s < 2; s++)
                    if (sof_mask[s]) begin
                        if (s == k) pend_m[s] = 1;
                        else begin col_m[s] = 0; line_m[s] = 0; end
                    end
            end else begin
                req_sof = '0;
            end
            #1;
            check_val("wvalid", m_wvalid, 1);
            check_val("wdata", m_wdata, (k == 1) ? req_data1 : req_data0);
            check_val("wlast", m_wlast, (beats == BL - 1));
            check_val("ren", req_ren, m_wready ? (2'b01 << k) : 2'b00);
            check_val("w_awvalid", m_awvalid, 0);
            if (m_wready) begin beats++; pop = 1; end
            cyc++;
        end
        check_val("beats", beats, BL);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (pop) begin
                if (k == 0) req_data0 = rnd_word(); else req_data1 = rnd_word();
                pop = 0;
            end
            m_wready = 1'b0; req_sof = '0;
            m_bvalid = (c >= b_dly);
            m_bresp = m_bvalid ? bresp : 2'b00;
            #1;
            check_val("bready", m_bready, 1);
            check_val("b_wvalid", m_wvalid, 0);
            check_val("b_ren", req_ren, 0);
            if (m_bvalid) break;
        end
        @(negedge clk);
        m_bvalid = 1'b0; m_bresp = '0;
        fd_exp = '0;
        if (pend_m[k]) begin
            col_m[k] = 0; line_m[k] = 0; pend_m[k] = 0;
        end else begin
            col_m[k]++;
            if (col_m[k] == COLS) begin
                col_m[k] = 0;
                line_m[k]++;
                if (line_m[k] == V) begin
                    line_m[k] = 0;
                    buf_m[k] = ~buf_m[k];
                    fd_exp[k] = 1'b1;
                end
            end
        end
        if (bresp != 2'b00) err_m = 1;
        #1;
        got_fd = frame_done;
        check_val("frame_done", frame_done, fd_exp);
        check_val("buf_sel", buf_sel, {buf_m[1], buf_m[0]});
        check_val("err", err, err_m);
        check_val("idle_bready", m_bready, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    initial begin
        req_data0 = rnd_word();
        req_data1 = rnd_word();
        do_reset();

        // both requesting from reset: 0,1,0
        run_burst(2'b11, 0, 0, 0, 2'b00, 2'b00, -1);
        check_val("alt_addr0", got_addr, 32'h1000_0000);
        run_burst(2'b11, 1, 0, 1, 2'b00, 2'b00, -1);
        check_val("alt_addr1", got_addr, 32'h1000_0A00);
        run_burst(2'b11, 0, 1, 0, 2'b00, 2'b00, -1);
        check_val("alt_addr2", got_addr, 32'h1000_0080);

        // reset in the middle of a W phase
        req_rdy = 2'b10; m_awready = 1'b1; m_wready = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check_val("mid_wvalid", m_wvalid, 1);
        do_reset();
        check_val("mid_ren_after", req_ren, 0);

        // requester 0 alone through a whole frame
        run_burst(2'b01, 0, 0, 0, 2'b00, 2'b00, -1);
        check_val("first_addr", got_addr, 32'h1000_0000);
        for (int i = 2; i <= 20; i++) run_burst(2'b01, 0, 0, 0, 2'b00, 2'b00, -1);
        run_burst(2'b01, 0, 0, 0, 2'b00, 2'b00, -1);
        check_val("burst21_addr", got_addr, 32'h1000_1400);
        for (int i = 22; i <= COLS * V; i++) run_burst(2'b01, 0, 0, 0, 2'b00, 2'b00, -1);
        check_val("frame_pulse", got_fd, 2'b01);
        check_val("frame_buf_sel", buf_sel, 2'b01);
        run_burst(2'b01, 0, 0, 0, 2'b00, 2'b00, -1);
        check_val("buf1_addr", got_addr, 32'h1038_4000);

        // long AW and W stalls
        run_burst(2'b10, 10, 10, 3, 2'b00, 2'b00, -1);

        // sof mid-burst plus error response
        do_reset();
        for (int i = 0; i < 4; i++) run_burst(2'b01, 0, 0, 0, 2'b00, 2'b00, -1);
        run_burst(2'b01, 0, 0, 1, 2'b10, 2'b01, 3);
        check_val("sof_burst5_addr", got_addr, 32'h1000_0200);
        check_val("err_set", err, 1);
        run_burst(2'b01, 0, 0, 0, 2'b00, 2'b00, -1);
        check_val("sof_next_addr", got_addr, 32'h1000_0000);
        run_burst(2'b11, 0, 0, 0, 2'b00, 2'b00, -1);
        check_val("err_sticky", err, 1);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 60; i++) begin
            logic [1:0] rdy, bresp, smask;
            rdy   = 2'($urandom_range(1, 3));
            bresp = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            smask = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_burst(rdy, $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3),
                      bresp, smask, $urandom_range(0, 15));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi4_stitch_wr_arbiter.md
AXI4_STITCH_WR_ARBITER -- requirements
Module: axi4_stitch_wr_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning AXI W data width in bits (one 32-bit pixel per 32 bits).
REQ-002 SHALL have parameter BURST_LEN, default 16, meaning beats per AW burst.
REQ-003 SHALL have parameter IMG_HDISP, default 640, meaning pixels per line per requester.
REQ-004 SHALL have parameter IMG_VDISP, default 480, meaning lines per frame.
REQ-005 SHALL have parameter BASE_ADDR, default 32'h1000_0000, meaning frame buffer 0 base address.
REQ-006 SHALL have parameter BUF_STRIDE, default 32'h0038_4000, meaning byte offset from buffer 0 to buffer 1.
REQ-007 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-008 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-009 SHALL have port req_rdy, input, 2, bit k high means requester k FIFO holds at least BURST_LEN words.
REQ-010 SHALL have port req_sof, input, 2, bit k is a one-cycle start-of-frame pulse from requester k.
REQ-011 SHALL have port req_data0, input, DATA_WIDTH, show-ahead FIFO head word of requester 0.
REQ-012 SHALL have port req_data1, input, DATA_WIDTH, show-ahead FIFO head word of requester 1.
REQ-013 SHALL have port req_ren, output, 2, FIFO read strobe to requester k.
REQ-014 SHALL have port m_awaddr, output, 32, burst start byte address.
REQ-015 SHALL have port m_awlen, output, 8, constant BURST_LEN-1.
REQ-016 SHALL have ports m_awvalid (output, 1) and m_awready (input, 1), the AXI AW handshake.
REQ-017 SHALL have port m_wdata, output, DATA_WIDTH, the granted requester's FIFO head word.
REQ-018 SHALL have ports m_wvalid (output, 1), m_wlast (output, 1) and m_wready (input, 1), the AXI W handshake.
REQ-019 SHALL have ports m_bvalid (input, 1), m_bresp (input, 2) and m_bready (output, 1), the AXI B handshake.
REQ-020 SHALL have port frame_done, output, 2, one-cycle pulse when requester k completes a frame.
REQ-021 SHALL have port buf_sel, output, 2, current write buffer (0/1) of requester k.
REQ-022 SHALL have port err, output, 1, sticky flag set by any nonzero m_bresp.

Function
REQ-023 SHALL implement FSM IDLE->AW->W->B->IDLE, exactly one burst outstanding at any time.
REQ-024 IDLE: grant the requester with req_rdy set; if both set, grant the one not granted last; the first grant after reset goes to requester 0; no grant if neither is set.
REQ-025 Grant and address SHALL be latched on IDLE exit; m_awvalid asserts in the next cycle, stays high with address stable until m_awready, then W.
REQ-026 W: m_wvalid=1, m_wdata=granted data, req_ren[k]=m_wvalid&m_wready; beat counter 0..BURST_LEN-1; m_wlast on beat BURST_LEN-1; the last accepted beat moves to B.
REQ-027 B: m_bready=1; m_bvalid moves to IDLE; m_bresp!=0 sets err, with no retry.
REQ-028 Address SHALL be BASE_ADDR + buf_sel[k]*BUF_STRIDE + line_k*(IMG_HDISP*8) + k*(IMG_HDISP*4) + col_k*(BURST_LEN*DATA_WIDTH/8), i.e. requester 0 fills the left half and requester 1 the right half of a 2*IMG_HDISP line.
REQ-029 Per-requester counters col_k (0..IMG_HDISP*4/(BURST_LEN*DATA_WIDTH/8)-1) and line_k (0..IMG_VDISP-1) SHALL advance on B completion; col wraps to 0 and increments line.
REQ-030 Line wrap from IMG_VDISP-1 SHALL clear both counters, toggle buf_sel[k] and pulse frame_done[k] in the same cycle.
REQ-031 req_sof[k] SHALL clear col_k and line_k without toggling buf_sel[k]; if k is mid-burst, it is held pending and applied at that burst's B completion, overriding the increment.
REQ-032 All address arithmetic SHALL be 32-bit unsigned, with wrap modulo 2^32.
REQ-033 Non-granted requester's req_ren bit SHALL be 0; W, AW and B outputs SHALL be 0 outside their state.

Reset
REQ-034 rst_n=0 at a clock edge SHALL force IDLE, all outputs 0 except m_awlen, counters 0, buf_sel=0, err=0, last-grant=1, pending sof cleared.
REQ-035 Reset mid-burst SHALL abandon the transaction without completing W beats.

Verification
REQ-036 req_rdy=2'b01 after reset -> m_awaddr=32'h1000_0000, 16 beats, m_wlast on beat 16, req_ren[0] pulses 16 times.
REQ-037 req_rdy=2'b11 held -> grants alternate 0,1,0; addresses 32'h1000_0000, 32'h1000_0A00, 32'h1000_0080.
REQ-038 Requester 0 completes 20 bursts -> 21st burst address 32'h1000_1400.
REQ-039 Requester 0 completes 9600 bursts -> frame_done[0] pulse, buf_sel[0]=1, next address 32'h1038_4000.
REQ-040 req_sof[0] during the W beat of burst 5, and m_bresp=2'b10 on that burst -> next requester 0 address 32'h1000_0000, err=1 and stays 1.
REQ-041 m_awready and m_wready held low for 10 cycles -> m_awaddr, m_wdata and m_wvalid stable, no req_ren.
